// File: rtl/jstk_pkg.sv
// Shared definitions for the joystick SPI link: responder state encoding,
// frame geometry and the byte packing used by both ends of the link.
package jstk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } jstkState_t;

    localparam int JSTK_NUM_BYTES    = 5;
    localparam int JSTK_CMD_LED_FLAG = 7;

    // Byte idx of the joystick report; indices past the report read as zero.
    function automatic logic [7:0] jstkPackByte(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b,
        input logic [2:0] idx
    );
        logic [7:0] res;
        case (idx)
            3'd0:    res = x[7:0];
            3'd1:    res = {6'b0, x[9:8]};
            3'd2:    res = y[7:0];
            3'd3:    res = {6'b0, y[9:8]};
            3'd4:    res = {5'b0, b};
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/spi_jstk_responder_sync_edge.sv
// N-stage input synchroniser with single-cycle rise/fall pulses derived
// from the synchronised level. The chain resets to the pin's idle level so
// reset itself never manufactures an edge on an idle line.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              levelPrev;

    // Shift the pin through the chain and keep one extra stage for edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            chain     <= {STAGES{IDLE_LEVEL}};
            levelPrev <= IDLE_LEVEL;
        end else begin
            chain     <= {chain[STAGES-2:0], pin};
            levelPrev <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~levelPrev;
    assign fall  = ~chain[STAGES-1] & levelPrev;

endmodule

// File: rtl/spi_jstk_responder.sv
// SPI mode-0 slave emulating the joystick Pmod: shifts out a frozen X/Y/button
// report MSB first and captures the master's command byte (LED bits).
module spi_jstk_responder
    import jstk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_BYTES   = JSTK_NUM_BYTES
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [9:0] xPos,
    input  logic [9:0] yPos,
    input  logic [2:0] btns,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    output logic       MISO_EN,
    output logic [7:0] rxCmd,
    output logic [1:0] ledState,
    output logic       frameDone,
    output logic       frameErr
);

    localparam logic [3:0] NB      = 4'(NUM_BYTES);
    localparam logic [7:0] HOLDOFF = 8'(SYNC_STAGES + 1);

    logic ssLevel, ssRise, ssFall;
    logic sclkLevel, sclkRise, sclkFall;
    logic mosiLevel, mosiRise, mosiFall;

    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) uSyncSs (
        .CLK(CLK), .RST(RST), .pin(SS),
        .level(ssLevel), .rise(ssRise), .fall(ssFall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) uSyncSclk (
        .CLK(CLK), .RST(RST), .pin(SCLK),
        .level(sclkLevel), .rise(sclkRise), .fall(sclkFall)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) uSyncMosi (
        .CLK(CLK), .RST(RST), .pin(MOSI),
        .level(mosiLevel), .rise(mosiRise), .fall(mosiFall)
    );

    jstkState_t stateReg, stateNext;
    logic [7:0] txReg, txNext;
    logic [7:0] rxReg, rxNext;
    logic [7:0] pendReg, pendNext;
    logic [2:0] bitCntReg, bitCntNext;
    logic [3:0] byteCntReg, byteCntNext;
    logic [9:0] xSnapReg, xSnapNext;
    logic [9:0] ySnapReg, ySnapNext;
    logic [2:0] bSnapReg, bSnapNext;
    logic [7:0] holdoffReg, holdoffNext;
    logic       misoReg, misoNext;
    logic       misoEnReg, misoEnNext;
    logic [7:0] rxCmdReg, rxCmdNext;
    logic [1:0] ledReg, ledNext;
    logic       doneReg, doneNext;
    logic       errReg, errNext;
    logic [7:0] nextByte;
    logic [7:0] rxShifted;

    // State and datapath registers; reset also arms the post-reset holdoff.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg   <= ST_IDLE;
            txReg      <= 8'h00;
            rxReg      <= 8'h00;
            pendReg    <= 8'h00;
            bitCntReg  <= 3'd0;
            byteCntReg <= 4'd0;
            xSnapReg   <= 10'd0;
            ySnapReg   <= 10'd0;
            bSnapReg   <= 3'd0;
            holdoffReg <= HOLDOFF;
            misoReg    <= 1'b0;
            misoEnReg  <= 1'b0;
            rxCmdReg   <= 8'h00;
            ledReg     <= 2'b00;
            doneReg    <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            txReg      <= txNext;
            rxReg      <= rxNext;
            pendReg    <= pendNext;
            bitCntReg  <= bitCntNext;
            byteCntReg <= byteCntNext;
            xSnapReg   <= xSnapNext;
            ySnapReg   <= ySnapNext;
            bSnapReg   <= bSnapNext;
            holdoffReg <= holdoffNext;
            misoReg    <= misoNext;
            misoEnReg  <= misoEnNext;
            rxCmdReg   <= rxCmdNext;
            ledReg     <= ledNext;
            doneReg    <= doneNext;
            errReg     <= errNext;
        end
    end

    // Frame sequencing. A falling SS seen while the holdoff is still running
    // reflects a pin level held across reset, not a fresh select, so it is
    // ignored. SS edges take priority over SCLK edges in the same cycle.
    always_comb begin
        stateNext   = stateReg;
        txNext      = txReg;
        rxNext      = rxReg;
        pendNext    = pendReg;
        bitCntNext  = bitCntReg;
        byteCntNext = byteCntReg;
        xSnapNext   = xSnapReg;
        ySnapNext   = ySnapReg;
        bSnapNext   = bSnapReg;
        holdoffNext = (holdoffReg != 8'd0) ? holdoffReg - 8'd1 : holdoffReg;
        misoNext    = misoReg;
        misoEnNext  = misoEnReg;
        rxCmdNext   = rxCmdReg;
        ledNext     = ledReg;
        doneNext    = 1'b0;
        errNext     = 1'b0;
        nextByte    = 8'h00;
        rxShifted   = {rxReg[6:0], mosiLevel};

        case (stateReg)
            ST_IDLE: begin
                misoEnNext = 1'b0;
                if (ssFall && holdoffReg == 8'd0) begin
                    xSnapNext   = xPos;
                    ySnapNext   = yPos;
                    bSnapNext   = btns;
                    nextByte    = jstkPackByte(xPos, yPos, btns, 3'd0);
                    txNext      = {nextByte[6:0], 1'b0};
                    misoNext    = nextByte[7];
                    misoEnNext  = 1'b1;
                    bitCntNext  = 3'd0;
                    byteCntNext = 4'd0;
                    rxNext      = 8'h00;
                    pendNext    = 8'h00;
                    stateNext   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ssRise) begin
                    misoNext   = 1'b0;
                    misoEnNext = 1'b0;
                    stateNext  = (byteCntReg >= NB && bitCntReg == 3'd0) ? ST_DONE : ST_ABORT;
                end else if (sclkRise) begin
                    rxNext     = rxShifted;
                    bitCntNext = bitCntReg + 3'd1;
                    if (bitCntReg == 3'd7) begin
                        if (byteCntReg < NB) begin
                            byteCntNext = byteCntReg + 4'd1;
                        end
                        if (byteCntReg == 4'd0) begin
                            pendNext = rxShifted;
                        end
                    end
                end else if (sclkFall) begin
                    if (bitCntReg == 3'd0) begin
                        if (byteCntReg < NB) begin
                            nextByte = jstkPackByte(xSnapReg, ySnapReg, bSnapReg, byteCntReg[2:0]);
                        end
                        misoNext = nextByte[7];
                        txNext   = {nextByte[6:0], 1'b0};
                    end else begin
                        misoNext = txReg[7];
                        txNext   = {txReg[6:0], 1'b0};
                    end
                end
            end
            ST_DONE: begin
                rxCmdNext = pendReg;
                if (pendReg[JSTK_CMD_LED_FLAG]) begin
                    ledNext = pendReg[1:0];
                end
                doneNext  = 1'b1;
                stateNext = ST_IDLE;
            end
            default: begin
                errNext   = 1'b1;
                stateNext = ST_IDLE;
            end
        endcase
    end

    assign MISO      = misoReg;
    assign MISO_EN   = misoEnReg;
    assign rxCmd     = rxCmdReg;
    assign ledState  = ledReg;
    assign frameDone = doneReg;
    assign frameErr  = errReg;

endmodule

// File: tb/tb_spi_jstk_responder.sv
// Directed bench: an SPI master model drives frames, a byte scoreboard holds
// the expected MISO stream, and pulse counters track frame completion.
module tb_spi_jstk_responder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [9:0] xPos = 10'd0;
    logic [9:0] yPos = 10'd0;
    logic [2:0] btns = 3'd0;
    logic       SS = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic       MISO_EN;
    logic [7:0] rxCmd;
    logic [1:0] ledState;
    logic       frameDone;
    logic       frameErr;

    int checks = 0;
    int errors = 0;
    int doneCnt = 0;
    int errCnt = 0;
    logic [7:0] sb[$];

    localparam int HALF = 8;

    spi_jstk_responder dut (
        .CLK(CLK), .RST(RST), .xPos(xPos), .yPos(yPos), .btns(btns),
        .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .MISO_EN(MISO_EN),
        .rxCmd(rxCmd), .ledState(ledState), .frameDone(frameDone), .frameErr(frameErr)
    );

    always #5 CLK = ~CLK;

    // Count completion pulses away from the active edge.
    always @(negedge CLK) begin
        if (frameDone) doneCnt++;
        if (frameErr) errCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic waitCyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Expected report byte, written out independently from the packing rules.
    function automatic logic [7:0] expByte(input logic [9:0] x, input logic [9:0] y,
                                           input logic [2:0] b, input int idx);
        if (idx == 0) return x[7:0];
        if (idx == 1) return {6'b0, x[9:8]};
        if (idx == 2) return y[7:0];
        if (idx == 3) return {6'b0, y[9:8]};
        if (idx == 4) return {5'b0, b};
        return 8'h00;
    endfunction

    task automatic ssLow();
        SS = 1'b0;
        waitCyc(HALF);
    endtask

    task automatic ssHigh();
        waitCyc(HALF);
        SS = 1'b1;
        waitCyc(12);
    endtask

    // One byte, mode 0: MISO sampled just before each rising SCLK.
    task automatic xferByte(input logic [7:0] tx, input string tag);
        logic [7:0] rx;
        logic [7:0] exp;
        rx = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            rx[i] = MISO;
            SCLK = 1'b1;
            waitCyc(HALF);
            SCLK = 1'b0;
            waitCyc(HALF);
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp = sb.pop_front();
            check(tag, {24'd0, rx}, {24'd0, exp});
            $display("byte %s rx=%h exp=%h", tag, rx, exp);
        end
    endtask

    // Full frame: command first, zeros after, expected bytes queued at SS fall.
    task automatic runFrame(input logic [7:0] cmd, input int nBytes, input bit changeX);
        for (int i = 0; i < nBytes; i++) sb.push_back(expByte(xPos, yPos, btns, i));
        ssLow();
        check("miso_en_sel", {31'd0, MISO_EN}, 32'd1);
        for (int i = 0; i < nBytes; i++) begin
            xferByte((i == 0) ? cmd : 8'h00, $sformatf("b%0d", i));
            if (changeX && i == 0) xPos = 10'h3FF;
        end
        ssHigh();
        check("miso_en_idle", {31'd0, MISO_EN}, 32'd0);
    endtask

    initial begin
        int d0;
        int e0;
        waitCyc(4);
        RST = 1'b0;
        waitCyc(2);
        check("rst_miso", {31'd0, MISO}, 32'd0);
        check("rst_miso_en", {31'd0, MISO_EN}, 32'd0);
        check("rst_rxcmd", {24'd0, rxCmd}, 32'h00);
        check("rst_led", {30'd0, ledState}, 32'd0);
        check("rst_done", {31'd0, frameDone}, 32'd0);
        check("rst_err", {31'd0, frameErr}, 32'd0);

        // Basic frame with LED flag set
        xPos = 10'h2A5; yPos = 10'h1F0; btns = 3'b101;
        d0 = doneCnt; e0 = errCnt;
        runFrame(8'h81, 5, 1'b0);
        check("f1_done", doneCnt - d0, 32'd1);
        check("f1_err", errCnt - e0, 32'd0);
        check("f1_rxcmd", {24'd0, rxCmd}, 32'h81);
        check("f1_led", {30'd0, ledState}, 32'd1);

        // Set LEDs to 10, then a flag-clear command must leave them alone
        runFrame(8'h82, 5, 1'b0);
        check("f2_led", {30'd0, ledState}, 32'd2);
        d0 = doneCnt;
        runFrame(8'h03, 5, 1'b0);
        check("f3_done", doneCnt - d0, 32'd1);
        check("f3_rxcmd", {24'd0, rxCmd}, 32'h03);
        check("f3_led", {30'd0, ledState}, 32'd2);

        // Abort after three bytes
        d0 = doneCnt; e0 = errCnt;
        runFrame(8'h84, 3, 1'b0);
        check("ab_err", errCnt - e0, 32'd1);
        check("ab_done", doneCnt - d0, 32'd0);
        check("ab_rxcmd", {24'd0, rxCmd}, 32'h03);
        check("ab_led", {30'd0, ledState}, 32'd2);

        // Seven-byte frame: trailing bytes read as zero
        xPos = 10'h3FF; yPos = 10'h155; btns = 3'b010;
        d0 = doneCnt; e0 = errCnt;
        runFrame(8'h80, 7, 1'b0);
        check("f7_done", doneCnt - d0, 32'd1);
        check("f7_err", errCnt - e0, 32'd0);
        check("f7_rxcmd", {24'd0, rxCmd}, 32'h80);
        check("f7_led", {30'd0, ledState}, 32'd0);

        // X changes after byte0 must not affect the frame in flight
        xPos = 10'h000;
        d0 = doneCnt;
        runFrame(8'h00, 5, 1'b1);
        check("fx_done", doneCnt - d0, 32'd1);
        check("fx_rxcmd", {24'd0, rxCmd}, 32'h00);

        // Reset during byte2
        runFrame(8'h81, 5, 1'b0);
        check("pre_rst_led", {30'd0, ledState}, 32'd1);
        xPos = 10'h2A5;
        for (int i = 0; i < 2; i++) sb.push_back(expByte(xPos, yPos, btns, i));
        ssLow();
        xferByte(8'h82, "r0");
        xferByte(8'h00, "r1");
        for (int i = 0; i < 3; i++) begin
            SCLK = 1'b1; waitCyc(HALF);
            SCLK = 1'b0; waitCyc(HALF);
        end
        d0 = doneCnt; e0 = errCnt;
        RST = 1'b1;
        waitCyc(2);
        RST = 1'b0;
        waitCyc(1);
        check("mid_rst_miso", {31'd0, MISO}, 32'd0);
        check("mid_rst_miso_en", {31'd0, MISO_EN}, 32'd0);
        check("mid_rst_rxcmd", {24'd0, rxCmd}, 32'h00);
        check("mid_rst_led", {30'd0, ledState}, 32'd0);
        waitCyc(10);
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b1; waitCyc(HALF);
            check("held_ss_miso_en", {31'd0, MISO_EN}, 32'd0);
            SCLK = 1'b0; waitCyc(HALF);
        end
        ssHigh();
        check("rst_no_done", doneCnt - d0, 32'd0);
        check("rst_no_err", errCnt - e0, 32'd0);
        d0 = doneCnt;
        runFrame(8'h83, 5, 1'b0);
        check("post_rst_done", doneCnt - d0, 32'd1);
        check("post_rst_rxcmd", {24'd0, rxCmd}, 32'h83);
        check("post_rst_led", {30'd0, ledState}, 32'd3);
        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
